id_operand_unit: RTL



---
 rtl/id_operand_unit_pkg.sv | 19 +
 rtl/id_operand_unit_regfile_2r1w.sv | 66 ++++++
 rtl/id_operand_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/id_operand_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_unit_pkg
// Purpose  : Shared pipeline definitions for the ID-stage operand block.
//            Forward-select encodings and the hard-wired zero register id.
// Revision : 1.0 - initial release
// ============================================================================
package id_operand_unit_pkg;

  // Forward select encodings carried into the ID/EXE register
  localparam logic [1:0] FWD_REG     = 2'b00;  // use id_a / id_b
  localparam logic [1:0] FWD_EXE     = 2'b01;  // EXE ALU result
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;  // MEM ALU result
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;  // MEM load data

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : id_operand_unit_pkg
`default_nettype wire

// File: rtl/id_operand_unit_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Purpose  : General register file, two async read ports plus an async debug
//            read port, one synchronous write port, async clear. Reads see a
//            same-cycle write (write-through). r0 is hard-wired to zero.
// Ports    : clk, rst           - clock, async active-high clear
//            i_we/i_wn/i_wd     - write enable / register / data
//            i_ra_n/i_rb_n      - read port A/B register numbers
//            i_dbg_n            - debug read register number
//            o_ra/o_rb/o_dbg    - read data
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w
  import id_operand_unit_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_wn,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra_n,
  input  logic [4:0]  i_rb_n,
  input  logic [4:0]  i_dbg_n,
  output logic [31:0] o_ra,
  output logic [31:0] o_rb,
  output logic [31:0] o_dbg
);

  localparam int c_NPORT = 3;

  logic [31:0] r_regs [NREG];
  logic [4:0]  w_rn   [c_NPORT];
  logic [31:0] w_rd   [c_NPORT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wn != REG_ZERO)) begin
      r_regs[i_wn] <= i_wd;
    end
  end

  assign w_rn[0] = i_ra_n;
  assign w_rn[1] = i_rb_n;
  assign w_rn[2] = i_dbg_n;

  // All read ports share one rule: r0 is zero, otherwise a pending write to
  // the same register is passed through ahead of the stored value.
  genvar k;
  generate
    for (k = 0; k < c_NPORT; k++) begin : g_rd
      assign w_rd[k] = (w_rn[k] == REG_ZERO)           ? 32'd0 :
                       (i_we && (i_wn == w_rn[k]))     ? i_wd  :
                                                         r_regs[w_rn[k]];
    end
  endgenerate

  assign o_ra  = w_rd[0];
  assign o_rb  = w_rd[1];
  assign o_dbg = w_rd[2];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/id_operand_unit.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_unit
// Purpose  : ID-stage operand block. Owns the register file, produces the ID
//            operands with WB bypass, EXE/MEM forward selects, load-use stall,
//            branch flush controls and a saturating stall-cycle counter.
// Ports    : clk, rst                     - clock, async active-high reset
//            wb_wreg/wb_rn/wb_data        - write-back port
//            id_rs/id_rt/id_use_rs/_rt    - ID source operands and use bits
//            exe_wreg/exe_m2reg/exe_rn    - EXE destination tag
//            mem_wreg/mem_m2reg/mem_rn    - MEM destination tag
//            exe_branch_taken             - taken branch resolved in EXE
//            id_a/id_b, id_fwd_a/id_fwd_b - operands and forward selects
//            stall/if_flush/id_flush      - pipeline register controls
//            stall_count                  - saturating stall counter
//            dbg_rn/dbg_data              - async debug read
// Revision : 1.0 - initial release
// ============================================================================
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_wreg,
  input  logic [4:0]       wb_rn,
  input  logic [31:0]      wb_data,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  input  logic             exe_branch_taken,
  output logic [31:0]      id_a,
  output logic [31:0]      id_b,
  output logic [1:0]       id_fwd_a,
  output logic [1:0]       id_fwd_b,
  output logic             stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic [CNT_W-1:0] stall_count,
  input  logic [4:0]       dbg_rn,
  output logic [31:0]      dbg_data
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_src_a;
  logic             w_src_b;
  logic             w_lu_a;
  logic             w_lu_b;
  logic             w_load_use;
  logic [CNT_W-1:0] r_stall_count;

  regfile_2r1w #(
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (wb_wreg),
    .i_wn    (wb_rn),
    .i_wd    (wb_data),
    .i_ra_n  (id_rs),
    .i_rb_n  (id_rt),
    .i_dbg_n (dbg_rn),
    .o_ra    (id_a),
    .o_rb    (id_b),
    .o_dbg   (dbg_data)
  );

  // A source takes part in hazard checks only if it is really read and is
  // not r0.
  assign w_src_a = id_use_rs && (id_rs != REG_ZERO);
  assign w_src_b = id_use_rt && (id_rt != REG_ZERO);

  // Load in EXE feeding a used source: data not available until MEM.
  assign w_lu_a = exe_wreg && exe_m2reg && (exe_rn != REG_ZERO) &&
                  w_src_a && (exe_rn == id_rs);
  assign w_lu_b = exe_wreg && exe_m2reg && (exe_rn != REG_ZERO) &&
                  w_src_b && (exe_rn == id_rt);
  assign w_load_use = w_lu_a || w_lu_b;

  function automatic logic [1:0] f_fwd(input logic       src_ok,
                                       input logic       lu,
                                       input logic [4:0] s,
                                       input logic       e_wreg,
                                       input logic       e_m2reg,
                                       input logic [4:0] e_rn,
                                       input logic       m_wreg,
                                       input logic       m_m2reg,
                                       input logic [4:0] m_rn);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src_ok && !lu) begin
      // EXE is younger than MEM, so it is checked first.
      if (e_wreg && !e_m2reg && (e_rn == s))
        sel = FWD_EXE;
      else if (m_wreg && (m_rn == s))
        sel = m_m2reg ? FWD_MEM_LD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

  assign id_fwd_a = f_fwd(w_src_a, w_lu_a, id_rs, exe_wreg, exe_m2reg, exe_rn,
                          mem_wreg, mem_m2reg, mem_rn);
  assign id_fwd_b = f_fwd(w_src_b, w_lu_b, id_rt, exe_wreg, exe_m2reg, exe_rn,
                          mem_wreg, mem_m2reg, mem_rn);

  // A taken branch squashes the stalled instruction, so the stall is dropped.
  assign stall    = w_load_use && !exe_branch_taken;
  assign if_flush = exe_branch_taken;
  assign id_flush = w_load_use || exe_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + c_CNT_ONE;
    end
  end

  assign stall_count = r_stall_count;

endmodule : id_operand_unit
`default_nettype wire
